// File: rtl/genomics_chunk_expander.sv
// genomics_chunk_expander
//   Stream kernel that expands one input chunk into N output chunks. N is taken from the
//   low CNT_WIDTH bits of the chunk. Output chunk k (k = 1..N) equals the input with every
//   LANE_WIDTH lane decremented by k. The lanes wrap independently and never borrow from a
//   neighbouring lane. The output is registered. A new chunk may be accepted in the same
//   cycle that the last chunk of the previous burst transfers.
//
//   Optional feature macro: GENOMICS_EXPANDER_DEBUG_EN
//     When it is defined, lane DEBUG_LANE of out_data shows {busy, in_cnt[14:0], out_cnt}.
//     This word is sampled whenever the output register loads. The decrement chain for that
//     lane still runs internally.
//
// Ports
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_ready   out  kernel accepts in_data this cycle
//   in_avail   in   in_data valid
//   in_data    in   input chunk
//   out_ready  in   downstream accepts out_data this cycle
//   out_avail  out  out_data valid (registered)
//   out_data   out  output chunk (registered)
//   busy       out  FSM not idle
//   in_cnt     out  accepted input chunks (wrapping)
//   out_cnt    out  transferred output chunks (wrapping)
//   drop_cnt   out  accepted chunks with N == 0 (saturating)
module genomics_chunk_expander #(
  parameter int unsigned C_DATA_WIDTH = 512,
  parameter int unsigned LANE_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned DEBUG_LANE   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    in_ready,
  input  logic                    in_avail,
  input  logic [C_DATA_WIDTH-1:0] in_data,
  input  logic                    out_ready,
  output logic                    out_avail,
  output logic [C_DATA_WIDTH-1:0] out_data,
  output logic                    busy,
  output logic [15:0]             in_cnt,
  output logic [15:0]             out_cnt,
  output logic [15:0]             drop_cnt
);

  localparam int unsigned NumLanes = C_DATA_WIDTH / LANE_WIDTH;

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  state_e                  state_q, state_d;
  logic [C_DATA_WIDTH-1:0] data_q, data_d;
  logic                    avail_q, avail_d;
  logic                    upd;
  logic [15:0]             in_cnt_q, out_cnt_q, drop_cnt_q;

  logic cnt_zero, in_n_zero, last, xfer, accept, load, drop;

  // Decrement each lane by one; lanes wrap independently.
  function automatic logic [C_DATA_WIDTH-1:0] lane_dec(input logic [C_DATA_WIDTH-1:0] d);
    logic [C_DATA_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      r[i*LANE_WIDTH +: LANE_WIDTH] = d[i*LANE_WIDTH +: LANE_WIDTH] - LANE_WIDTH'(1);
    end
    return r;
  endfunction

  // The count lives in the low bits of lane 0, so it reaches zero on the last chunk.
  assign cnt_zero  = (data_q[CNT_WIDTH-1:0] == '0);
  assign in_n_zero = (in_data[CNT_WIDTH-1:0] == '0);
  assign last      = (state_q == StExpand) && avail_q && cnt_zero;
  assign xfer      = avail_q && out_ready;
  // Combinational out_ready -> in_ready path gives a zero-bubble handoff between bursts.
  assign in_ready  = (state_q == StIdle) || (last && out_ready);
  assign accept    = in_ready && in_avail;
  assign load      = accept && !in_n_zero;
  assign drop      = accept && in_n_zero;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    avail_d = avail_q;
    upd     = 1'b0;
    case (state_q)
      StIdle: begin
        if (load) begin
          data_d  = lane_dec(in_data);
          avail_d = 1'b1;
          upd     = 1'b1;
          state_d = StExpand;
        end
      end
      StExpand: begin
        if (xfer) begin
          if (!cnt_zero) begin
            data_d = lane_dec(data_q);
            upd    = 1'b1;
          end else if (load) begin
            data_d = lane_dec(in_data);
            upd    = 1'b1;
          end else begin
            avail_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        avail_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      avail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      avail_q <= avail_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (accept) in_cnt_q <= in_cnt_q + 16'd1;
      if (xfer) out_cnt_q <= out_cnt_q + 16'd1;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_avail = avail_q;
  assign in_cnt    = in_cnt_q;
  assign out_cnt   = out_cnt_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef GENOMICS_EXPANDER_DEBUG_EN
  logic [LANE_WIDTH-1:0] dbg_q;
  logic [31:0]           dbg_word;

  assign dbg_word = {busy, in_cnt_q[14:0], out_cnt_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dbg_q <= '0;
    end else if (upd) begin
      dbg_q <= LANE_WIDTH'(dbg_word);
    end
  end

  always_comb begin
    out_data = data_q;
    out_data[DEBUG_LANE*LANE_WIDTH +: LANE_WIDTH] = dbg_q;
  end
`else
  assign out_data = data_q;
`endif

endmodule

// File: tb/tb_genomics_chunk_expander.sv
// Scoreboard bench for genomics_chunk_expander (default build, 512/32/8).
// Expected chunks are queued at input acceptance and compared at output transfer.
module tb_genomics_chunk_expander;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_ready, in_avail, out_ready, out_avail, busy;
  logic [DW-1:0] in_data, out_data;
  logic [15:0]   in_cnt, out_cnt, drop_cnt;

  int            n_checks = 0;
  int            n_errors = 0;
  int            xfer_seen = 0;
  logic [DW-1:0] sb_q[$];
  logic          acc_busy;

  always #5 clk = ~clk;

  genomics_chunk_expander dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_ready (in_ready),
    .in_avail (in_avail),
    .in_data  (in_data),
    .out_ready(out_ready),
    .out_avail(out_avail),
    .out_data (out_data),
    .busy     (busy),
    .in_cnt   (in_cnt),
    .out_cnt  (out_cnt),
    .drop_cnt (drop_cnt)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: chunk k = every 32-bit lane minus k.
  function automatic logic [DW-1:0] exp_chunk(input logic [DW-1:0] d, input int k);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = d[i*32 +: 32] - 32'(k);
    return r;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [31:0] v, input logic [7:0] n);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = v;
    r[7:0] = n;
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset_n && out_avail && out_ready) begin
      if (sb_q.size() == 0) check_eq("sb_unexpected_out", DW'(sb_q.size()), DW'(1));
      else check_eq("out_chunk", out_data, sb_q.pop_front());
      xfer_seen++;
    end
  end

  // Offer d until accepted; push the expected burst at the accepting edge.
  task automatic send(input logic [DW-1:0] d);
    logic acc;
    acc      = 1'b0;
    in_data  = d;
    in_avail = 1'b1;
    for (int c = 0; c < 1000 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc      = 1'b1;
        acc_busy = busy;
        for (int k = 1; k <= int'(d[7:0]); k++) sb_q.push_back(exp_chunk(d, k));
      end
      @(posedge clk);
      #1;
    end
    in_avail = 1'b0;
    check_eq("send_accepted", DW'(acc), DW'(1));
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) break;
    end
    check_eq("drain_left", DW'(sb_q.size()), DW'(0));
    check_eq("drain_busy", DW'(busy), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] d, first;
    logic [15:0]   oc0;
    int            base;
    reset_n   = 1'b0;
    in_avail  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    acc_busy  = 1'b0;
    #12;
    check_eq("rst_out_avail", DW'(out_avail), DW'(0));
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_busy", DW'(busy), DW'(0));
    check_eq("rst_in_ready", DW'(in_ready), DW'(1));
    check_eq("rst_cnts", {in_cnt, out_cnt, drop_cnt}, '0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk) #1;

    // Single burst, N=3
    send(mk(32'h10, 8'd3));
    wait_drain();
    check_eq("single_in_ready", DW'(in_ready), DW'(1));
    check_eq("single_out_cnt", DW'(out_cnt), DW'(3));

    // Backpressure, N=2
    @(posedge clk) #1;
    out_ready = 1'b0;
    d = mk(32'h20, 8'd2);
    first = exp_chunk(d, 1);
    oc0 = out_cnt;
    send(d);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("bp_avail", DW'(out_avail), DW'(1));
      check_eq("bp_stable", out_data, first);
    end
    @(posedge clk) #1;
    out_ready = 1'b1;
    wait_drain();
    check_eq("bp_out_cnt", DW'(out_cnt - oc0), DW'(2));

    // Back-to-back: second chunk accepted during the last transfer of the first
    @(posedge clk) #1;
    send(mk(32'h30, 8'd2));
    send(mk(32'h40, 8'd1));
    check_eq("b2b_zero_bubble", DW'(acc_busy), DW'(1));
    wait_drain();

    // Zero count
    @(posedge clk) #1;
    send(mk(32'h50, 8'd0));
    @(negedge clk);
    check_eq("zero_out_avail", DW'(out_avail), DW'(0));
    check_eq("zero_drop_cnt", DW'(drop_cnt), DW'(1));
    check_eq("zero_in_ready", DW'(in_ready), DW'(1));

    // Lane wrap
    @(posedge clk) #1;
    d = mk(32'h77, 8'd1);
    d[5*32 +: 32] = 32'h0;
    send(d);
    check_eq("wrap_lane5", DW'(out_data[5*32 +: 32]), DW'(32'hFFFFFFFF));
    check_eq("wrap_lane4", DW'(out_data[4*32 +: 32]), DW'(32'h76));
    wait_drain();
    check_eq("tot_in_cnt", DW'(in_cnt), DW'(6));
    check_eq("tot_out_cnt", DW'(out_cnt), DW'(9));

    // Reset mid-burst
    @(posedge clk) #1;
    base = xfer_seen;
    d = mk(32'h1000, 8'd200);
    send(d);
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      if (xfer_seen >= base + 10) break;
    end
    check_eq("mid_xfers", DW'(xfer_seen - base >= 10), DW'(1));
    #2;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    check_eq("mid_out_avail", DW'(out_avail), DW'(0));
    check_eq("mid_busy", DW'(busy), DW'(0));
    check_eq("mid_cnts", {in_cnt, out_cnt, drop_cnt}, '0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk) #1;
    send(mk(32'h99, 8'd1));
    wait_drain();
    check_eq("post_in_cnt", DW'(in_cnt), DW'(1));
    check_eq("post_out_cnt", DW'(out_cnt), DW'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
